evt_encoder_32to5: RTL

- Converts 32 single-cycle event strobes into a stream of 5-bit indices, one per valid/ready transfer. It is the reverse of the register-file write-select decoder.
- Events are held in a 32-bit pending register until they are issued. Arbitration is round-robin or fixed-priority.
- It sits between the exception/hazard event sources and the consumer that takes one encoded index per cycle (trap handler sequencer, scoreboard release).

---
 rtl/evt_enc_pkg.sv | 16 +
 rtl/rr_find_first.sv | 33 +++
 rtl/evt_encoder_32to5.sv | 118 +++++++++++
 3 files changed

// File: rtl/evt_enc_pkg.sv
// Shared constants, types and output-stage state encoding for the
// 32-to-5 event encoder.
package evt_enc_pkg;

  localparam int N_EVT = 32;
  localparam int IDX_W = 5;

  typedef logic [IDX_W-1:0] evt_idx_t;
  typedef logic [N_EVT-1:0] evt_vec_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_find_first.sv
// Combinational search for the first set bit of vec, starting at start and
// wrapping from the top bit back to bit 0. A start of 0 gives fixed priority.
module rr_find_first
  import evt_enc_pkg::*;
(
  input  evt_vec_t vec,
  input  evt_idx_t start,
  output evt_idx_t idx,
  output logic     found
);

  evt_vec_t w_rot;
  evt_idx_t w_low;

  // A shift by the full width yields zero, which is what start == 0 needs.
  assign w_rot = (vec >> start) | (vec << (6'd32 - {1'b0, start}));

  // Scan downward so the last hit recorded is the lowest set bit.
  always_comb begin
    w_low = {IDX_W{1'b0}};
    for (int i = N_EVT - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_low = IDX_W'(i);
      end else begin
        w_low = w_low;
      end
    end
  end

  assign idx   = w_low + start;
  assign found = |vec;

endmodule

// File: rtl/evt_encoder_32to5.sv
// Collects single-cycle event strobes into a pending mask and issues them one
// index per valid/ready transfer, round-robin or lowest-index-first.
module evt_encoder_32to5
  import evt_enc_pkg::*;
#(
  parameter int N_EVT       = 32,
  parameter int IDX_W       = 5,
  parameter int ROUND_ROBIN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_EVT-1:0] evt,
  input  logic             clr,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic [N_EVT-1:0] pending,
  output logic             overflow
);

  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [N_EVT-1:0] VEC_ONE = {{(N_EVT-1){1'b0}}, 1'b1};

  out_state_e       r_state, w_state_nxt;
  logic [N_EVT-1:0] r_pending, w_pending_nxt, w_issue_mask;
  logic [IDX_W-1:0] r_out_idx, w_out_idx_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt, w_start, w_sel;
  logic             r_overflow, w_overflow_nxt;
  logic             w_found, w_load;

  assign w_start = (ROUND_ROBIN != 0) ? r_ptr : {IDX_W{1'b0}};

  rr_find_first u_find (
    .vec   (r_pending),
    .start (w_start),
    .idx   (w_sel),
    .found (w_found)
  );

  // Output-stage transitions plus pending/pointer/overflow next state.
  always_comb begin
    w_state_nxt    = r_state;
    w_out_idx_nxt  = r_out_idx;
    w_ptr_nxt      = r_ptr;
    w_load         = 1'b0;
    w_issue_mask   = {N_EVT{1'b0}};

    case (r_state)
      ST_EMPTY: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (w_found) begin
            w_load      = 1'b1;
            w_state_nxt = ST_FULL;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase

    if (w_load) begin
      w_issue_mask  = VEC_ONE << w_sel;
      w_out_idx_nxt = w_sel;
      w_ptr_nxt     = w_sel + IDX_ONE;
    end else begin
      w_issue_mask  = {N_EVT{1'b0}};
    end

    // A new strobe on the bit being issued re-arms it rather than overflowing.
    w_pending_nxt  = (r_pending & ~w_issue_mask) | evt;
    w_overflow_nxt = r_overflow | (|(evt & r_pending & ~w_issue_mask));

    if (clr) begin
      w_pending_nxt  = {N_EVT{1'b0}};
      w_state_nxt    = ST_EMPTY;
      w_ptr_nxt      = {IDX_W{1'b0}};
      w_overflow_nxt = 1'b0;
    end else begin
      w_pending_nxt  = w_pending_nxt;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_pending  <= {N_EVT{1'b0}};
      r_out_idx  <= {IDX_W{1'b0}};
      r_ptr      <= {IDX_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_out_idx  <= w_out_idx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_idx   = r_out_idx;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule
